// File: rtl/uart_link.sv
// uart_link: full-duplex UART with RX FIFO and sticky error flags.
// Define UART_LINK_LOOPBACK_EN to add the loopback port that routes TX into RX.
module uart_link #(
  parameter real CLK_FREQ      = 50_000_000.0,
  parameter int  BAUD_RATE     = 3_000_000,
  parameter int  DATA_BITS     = 8,
  parameter int  PARITY        = 0,
  parameter int  STOP_BITS     = 1,
  parameter int  RX_FIFO_DEPTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 err_clr,
`ifdef UART_LINK_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 rx_busy,
  output logic                 tx_busy,
  output logic                 rx_error,
  output logic                 rx_overflow
);
  localparam int CPB = $rtoi(CLK_FREQ / BAUD_RATE + 0.5);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [15:0] HALF = 16'(CPB / 2 - 1);
  localparam logic [15:0] LAST = 16'(CPB - 1);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  if (CPB < 2) begin : g_cpb_chk
    $error("uart_link: CLK_FREQ/BAUD_RATE must round to at least 2");
  end
  state_t r_tx_st, w_tx_st, r_rx_st, w_rx_st;
  logic [15:0] r_tx_cnt, w_tx_cnt, r_rx_cnt, w_rx_cnt;
  logic [3:0] r_tx_bit, w_tx_bit, r_rx_bit, w_rx_bit;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh, r_rx_sh, w_rx_sh;
  logic r_tx_par, w_tx_par, r_txd, w_txd, w_tx_end, w_rx_end, w_rx_in;
  logic r_s1, r_s2, r_s3, r_rx_bad, w_rx_bad, w_rx_fin, r_push, r_perr;
  logic r_err, r_ovf, w_full, w_pop, w_wr;
  logic [AW:0] r_wp, r_rp;
  logic [DATA_BITS-1:0] r_mem [RX_FIFO_DEPTH];
`ifdef UART_LINK_LOOPBACK_EN
  assign w_rx_in = loopback ? r_txd : rxd;
  assign txd = loopback | r_txd;
`else
  assign w_rx_in = rxd;
  assign txd = r_txd;
`endif
  assign tx_ready = (r_tx_st == IDLE) & ~rst;
  assign tx_busy = r_tx_st != IDLE;
  assign rx_busy = r_rx_st != IDLE;
  assign w_tx_end = r_tx_cnt == LAST;
  assign w_rx_end = r_rx_cnt == LAST;
  always_comb begin
    w_tx_st = r_tx_st;
    w_tx_cnt = w_tx_end ? '0 : r_tx_cnt + 16'd1;
    w_tx_bit = r_tx_bit;
    w_tx_sh = r_tx_sh;
    w_tx_par = r_tx_par;
    case (r_tx_st)
      IDLE: begin
        w_tx_cnt = '0;
        if (tx_valid && tx_ready) begin
          w_tx_st = START;
          w_tx_sh = tx_data;
          w_tx_par = (PARITY == 1) ? ~^tx_data : ^tx_data;
        end
      end
      START: if (w_tx_end) w_tx_st = DATA;
      DATA: if (w_tx_end) begin
        w_tx_sh = r_tx_sh >> 1;
        w_tx_bit = (r_tx_bit == DLAST) ? '0 : r_tx_bit + 4'd1;
        if (r_tx_bit == DLAST) w_tx_st = (PARITY != 0) ? PAR : STOP;
      end
      PAR: if (w_tx_end) w_tx_st = STOP;
      STOP: if (w_tx_end) begin
        w_tx_bit = (r_tx_bit == SLAST) ? '0 : r_tx_bit + 4'd1;
        if (r_tx_bit == SLAST) w_tx_st = IDLE;
      end
      default: w_tx_st = IDLE;
    endcase
    // line level is derived from the next state so txd is a clean register output
    w_txd = (w_tx_st == START) ? 1'b0 : (w_tx_st == DATA) ? w_tx_sh[0] : (w_tx_st == PAR) ? w_tx_par : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st <= IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_txd <= 1'b1;
    end else begin
      r_tx_st <= w_tx_st;
      r_tx_cnt <= w_tx_cnt;
      r_tx_bit <= w_tx_bit;
      r_txd <= w_txd;
    end
    r_tx_sh <= w_tx_sh;
    r_tx_par <= w_tx_par;
  end
  always_comb begin
    w_rx_st = r_rx_st;
    w_rx_cnt = w_rx_end ? '0 : r_rx_cnt + 16'd1;
    w_rx_bit = r_rx_bit;
    w_rx_sh = r_rx_sh;
    w_rx_bad = r_rx_bad;
    w_rx_fin = 1'b0;
    case (r_rx_st)
      IDLE: begin
        w_rx_cnt = '0;
        w_rx_bad = 1'b0;
        if (r_s3 && !r_s2) w_rx_st = START;
      end
      START: if (r_rx_cnt == HALF) begin
        w_rx_cnt = '0;
        w_rx_st = r_s2 ? IDLE : DATA;
      end
      DATA: if (w_rx_end) begin
        w_rx_sh = {r_s2, r_rx_sh[DATA_BITS-1:1]};
        w_rx_bit = (r_rx_bit == DLAST) ? '0 : r_rx_bit + 4'd1;
        if (r_rx_bit == DLAST) w_rx_st = (PARITY != 0) ? PAR : STOP;
      end
      PAR: if (w_rx_end) begin
        w_rx_bad = r_s2 ^ ((PARITY == 1) ? ~^r_rx_sh : ^r_rx_sh);
        w_rx_st = STOP;
      end
      STOP: if (w_rx_end) begin
        w_rx_bad = r_rx_bad | ~r_s2;
        w_rx_bit = (r_rx_bit == SLAST) ? '0 : r_rx_bit + 4'd1;
        w_rx_fin = r_rx_bit == SLAST;
        if (r_rx_bit == SLAST) w_rx_st = IDLE;
      end
      default: w_rx_st = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
      r_rx_st <= IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_bad <= 1'b0;
      r_push <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_s1 <= w_rx_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_rx_st <= w_rx_st;
      r_rx_cnt <= w_rx_cnt;
      r_rx_bit <= w_rx_bit;
      r_rx_bad <= w_rx_bad;
      r_push <= w_rx_fin & ~w_rx_bad;
      r_perr <= w_rx_fin & w_rx_bad;
    end
    r_rx_sh <= w_rx_sh;
  end
  // pointers carry one extra wrap bit to tell full from empty
  assign w_full = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign rx_valid = r_wp != r_rp;
  assign rx_data = r_mem[r_rp[AW-1:0]];
  assign w_pop = rx_valid & rx_ready;
  assign w_wr = r_push & (~w_full | w_pop);
  assign rx_error = r_err;
  assign rx_overflow = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_wp <= r_wp + {{AW{1'b0}}, w_wr};
      r_rp <= r_rp + {{AW{1'b0}}, w_pop};
      r_err <= r_perr | (r_err & ~err_clr);
      r_ovf <= (r_push & w_full & ~w_pop) | (r_ovf & ~err_clr);
    end
    if (w_wr) r_mem[r_wp[AW-1:0]] <= r_rx_sh;
  end
endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: randomized directed checks of uart_link against a frame-level reference model.
// Instances: a = 8N1 depth 4, b = 8E1 depth 8, c = 7N2 depth 4 with TX looped into RX.
module tb_uart_link;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  int sel = 0;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  logic a_rxd, a_txd, a_txr, a_rxv, a_rb, a_tb, a_err, a_ovf;
  logic a_txv = 1'b0, a_rxr = 1'b0, a_clr = 1'b0;
  logic [7:0] a_txdat = '0, a_rxdat;
  logic b_rxd, b_txd, b_txr, b_rxv, b_rb, b_tb, b_err, b_ovf;
  logic b_txv = 1'b0, b_rxr = 1'b0, b_clr = 1'b0;
  logic [7:0] b_txdat = '0, b_rxdat;
  logic c_rxd, c_txd, c_txr, c_rxv, c_rb, c_tb, c_err, c_ovf;
  logic c_txv = 1'b0, c_rxr = 1'b0, c_clr = 1'b0;
  logic [6:0] c_txdat = '0, c_rxdat;
  assign a_rxd = (sel == 0) ? line : 1'b1;
  assign b_rxd = (sel == 1) ? line : 1'b1;
`ifdef UART_LINK_LOOPBACK_EN
  logic c_loop = 1'b1;
  assign c_rxd = 1'b1;
`else
  assign c_rxd = c_txd;
`endif
  uart_link #(.CLK_FREQ(16.0), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rxd(a_rxd), .txd(a_txd), .tx_data(a_txdat), .tx_valid(a_txv), .tx_ready(a_txr),
    .rx_data(a_rxdat), .rx_valid(a_rxv), .rx_ready(a_rxr), .err_clr(a_clr),
`ifdef UART_LINK_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_busy(a_rb), .tx_busy(a_tb), .rx_error(a_err), .rx_overflow(a_ovf));
  uart_link #(.CLK_FREQ(16.0), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .RX_FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .rxd(b_rxd), .txd(b_txd), .tx_data(b_txdat), .tx_valid(b_txv), .tx_ready(b_txr),
    .rx_data(b_rxdat), .rx_valid(b_rxv), .rx_ready(b_rxr), .err_clr(b_clr),
`ifdef UART_LINK_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_busy(b_rb), .tx_busy(b_tb), .rx_error(b_err), .rx_overflow(b_ovf));
  uart_link #(.CLK_FREQ(16.0), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .rxd(c_rxd), .txd(c_txd), .tx_data(c_txdat), .tx_valid(c_txv), .tx_ready(c_txr),
    .rx_data(c_rxdat), .rx_valid(c_rxv), .rx_ready(c_rxr), .err_clr(c_clr),
`ifdef UART_LINK_LOOPBACK_EN
    .loopback(c_loop),
`endif
    .rx_busy(c_rb), .tx_busy(c_tb), .rx_error(c_err), .rx_overflow(c_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // serial frame, LSB first from bit 0: start, data, optional parity, then stop ones
  function automatic logic [15:0] frame(input logic [8:0] d, input int db, input int par);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (par != 0) f[1+db] = (par == 2) ? ones[0] : ~ones[0];
    return f;
  endfunction

  task automatic drive(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      line = f[i];
      repeat (CPB) @(negedge clk);
    end
    line = 1'b1;
  endtask

  task automatic pop(input int u, input logic [8:0] exp, input string tag);
    chk({tag, "_valid"}, u == 0 ? a_rxv : u == 1 ? b_rxv : c_rxv, 1);
    chk({tag, "_data"}, u == 0 ? {1'b0, a_rxdat} : u == 1 ? {1'b0, b_rxdat} : {2'b0, c_rxdat}, exp);
    if (u == 0) a_rxr = 1'b1;
    else if (u == 1) b_rxr = 1'b1;
    else c_rxr = 1'b1;
    @(negedge clk);
    a_rxr = 1'b0;
    b_rxr = 1'b0;
    c_rxr = 1'b0;
  endtask

  task automatic tx_a(input logic [7:0] d);
    logic [15:0] f;
    int t;
    f = frame({1'b0, d}, 8, 0);
    t = 0;
    while (!a_txr && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("a_txr_wait", a_txr, 1);
    a_txdat = d;
    a_txv = 1'b1;
    @(negedge clk);
    a_txv = 1'b0;
    for (int k = 0; k <= 10 * CPB; k++) begin
      if (k == 0) chk("a_tx_busy", a_tb, 1);
      if (k % CPB == CPB / 2) chk($sformatf("a_txd_bit%0d_%02h", k / CPB, d), a_txd, f[k / CPB]);
      if (k == 10 * CPB - 1) chk("a_txr_low", a_txr, 0);
      if (k == 10 * CPB) chk("a_txr_high", a_txr, 1);
      if (k < 10 * CPB) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] f;
    logic [7:0] d;
    logic [7:0] q_a[$];
    logic [6:0] qc[4];
    logic exp_ovf, exp_err, bad;
    int t, ext_low;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", a_txr, 0);
    chk("rst_txd", a_txd, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_ready", a_txr, 1);
    chk("post_rst_rx_valid", a_rxv, 0);
    chk("post_rst_flags", {a_rb, a_tb, a_err, a_ovf}, 0);
    chk("post_rst_b_valid", b_rxv, 0);
    chk("post_rst_c_valid", c_rxv, 0);
    tx_a(8'hA5);
    for (int i = 0; i < 3; i++) tx_a(8'($urandom));
    sel = 0;
    drive(frame(9'h03C, 8, 0), 10);
    repeat (2) @(negedge clk);
    chk("a_rx_good_err", a_err, 0);
    pop(0, 9'h03C, "a_rx_3c");
    chk("a_rx_drained", a_rxv, 0);
    f = frame(9'h03C, 8, 0);
    f[9] = 1'b0;
    drive(f, 10);
    repeat (2) @(negedge clk);
    chk("a_frame_err", a_err, 1);
    chk("a_frame_nopush", a_rxv, 0);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    chk("a_err_clr", a_err, 0);
    line = 1'b0;
    repeat (5) @(negedge clk);
    line = 1'b1;
    chk("glitch_busy", a_rb, 1);
    repeat (20) @(negedge clk);
    chk("glitch_idle", a_rb, 0);
    chk("glitch_nopush", a_rxv, 0);
    chk("glitch_noerr", a_err, 0);
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      if (q_a.size() < 4) q_a.push_back(d);
      else exp_ovf = 1'b1;
      drive(frame({1'b0, d}, 8, 0), 10);
    end
    repeat (2) @(negedge clk);
    chk("a_overflow", a_ovf, exp_ovf);
    chk("a_overflow_noerr", a_err, 0);
    t = 0;
    while (q_a.size() > 0 && t < 8) begin
      pop(0, {1'b0, q_a.pop_front()}, $sformatf("a_fifo%0d", t));
      t++;
    end
    chk("a_fifo_empty", a_rxv, 0);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    chk("a_ovf_clr", a_ovf, 0);
    sel = 1;
    drive(frame(9'h03C, 8, 2), 11);
    repeat (2) @(negedge clk);
    chk("b_parity_ok_err", b_err, 0);
    pop(1, 9'h03C, "b_rx_3c");
    exp_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      bad = (i == 2) ? 1'b1 : (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      f = frame({1'b0, d}, 8, 2);
      if (bad) f[9] = ~f[9];
      drive(f, 11);
      repeat (2) @(negedge clk);
      exp_err = exp_err | bad;
      chk($sformatf("b_err%0d", i), b_err, exp_err);
      chk($sformatf("b_push%0d", i), b_rxv, !bad);
      if (!bad) pop(1, {1'b0, d}, $sformatf("b_rx%0d", i));
    end
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    chk("b_err_clr", b_err, 0);
    sel = 2;
    qc[0] = 7'h55;
    qc[1] = 7'h2A;
    qc[2] = 7'($urandom);
    qc[3] = 7'($urandom);
    ext_low = 0;
    c_txv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_txdat = qc[i];
      t = 0;
      while (!c_txr && t < 400) begin
        @(negedge clk);
        t++;
        ext_low += int'(c_txd !== 1'b1);
      end
      chk("c_handshake", c_txr, 1);
      if (i > 0) chk($sformatf("c_gap%0d", i), t, 10 * CPB);
      @(negedge clk);
    end
    c_txv = 1'b0;
    t = 0;
    while (c_tb && t < 400) begin
      @(negedge clk);
      t++;
      ext_low += int'(c_txd !== 1'b1);
    end
    chk("c_tx_idle", c_tb, 0);
    repeat (CPB) @(negedge clk);
`ifdef UART_LINK_LOOPBACK_EN
    chk("c_ext_txd_high", ext_low, 0);
`endif
    chk("c_noerr", {c_err, c_ovf}, 0);
    for (int i = 0; i < 4; i++) pop(2, {2'b0, qc[i]}, $sformatf("c_loop%0d", i));
    chk("c_empty", c_rxv, 0);
    c_txdat = 7'h33;
    c_txv = 1'b1;
    @(negedge clk);
    c_txv = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    chk("c_mid_rx_busy", c_rb, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("c_rst_txd", c_txd, 1);
    chk("c_rst_state", {c_rxv, c_tb, c_rb}, 0);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("c_rst_discard", c_rxv, 0);
    chk("c_rst_noerr", c_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
